wt_dcache_mem_responder: RTL and testbench

On-chip SRAM responder for the write-through D$ memory-side request/return interface. It sits where the memory adapter normally sits and terminates D$ loads and stores locally. Loads return a full cache line; stores write bytes selectively and are acknowledged by transaction ID. It serves one transaction at a time through a request/ack handshake, and every return is a single-cycle valid pulse.

---
 rtl/wt_dcache_mem_responder.sv | 156 +++++++++++++++
 tb/tb_wt_dcache_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_mem_responder.sv
// On-chip SRAM responder for the write-through D$ memory interface.
// Serves one load/store at a time; loads return a full line, stores are byte-enabled.
//
// state | meaning
// IDLE  | ack_o follows req_i; decode and capture the accepted request
// READ  | issue line-word reads (1-cycle SRAM latency) and assemble the line
// WRITE | single byte-enabled SRAM write
// RESP  | one-cycle return pulse
module wt_dcache_mem_responder #(
   parameter int unsigned          AddrWidth = 64,
   parameter logic [AddrWidth-1:0] BaseAddr  = 'h8000_0000,
   parameter int unsigned          MemWords  = 4096,
   parameter int unsigned          LineWidth = 128,
   parameter int unsigned          TidWidth  = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_i,
   output logic                 ack_o,
   input  logic [1:0]           req_rtype_i,
   input  logic                 req_nc_i,
   input  logic [TidWidth-1:0]  req_tid_i,
   input  logic [AddrWidth-1:0] req_paddr_i,
   input  logic [63:0]          req_data_i,
   input  logic [7:0]           req_be_i,
   output logic                 rtrn_vld_o,
   output logic [1:0]           rtrn_rtype_o,
   output logic [TidWidth-1:0]  rtrn_tid_o,
   output logic [LineWidth-1:0] rtrn_data_o
);

   localparam int unsigned N    = LineWidth / 64;
   localparam int unsigned IdxW = $clog2(MemWords);
   localparam int unsigned CntW = $clog2(N + 1);
   localparam logic [IdxW-1:0] LineMask = IdxW'(N - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t               state_q;
   logic                 nc_q;
   logic [TidWidth-1:0]  tid_q;
   logic [IdxW-1:0]      idx_q;
   logic [63:0]          data_q;
   logic [7:0]           be_q;
   logic [CntW-1:0]      cnt_q;
   logic [LineWidth-1:0] line_q;
   logic [LineWidth-1:0] line_next;
   logic [63:0]          rd_data;
   logic [63:0]          mem [MemWords];

   logic [AddrWidth-1:0] off;
   logic                 in_range;
   logic                 req_err;
   logic [IdxW-1:0]      req_idx;
   logic [CntW-1:0]      nwords;
   logic [CntW-1:0]      slot;
   logic                 rd_en;
   logic [IdxW-1:0]      rd_idx;

   // Subtraction wraps for addresses below the base; the explicit >= keeps them out of range.
   assign off      = req_paddr_i - BaseAddr;
   assign in_range = (req_paddr_i >= BaseAddr) && ((off >> 3) < AddrWidth'(MemWords));
   assign req_err  = req_rtype_i[1] || !in_range;
   assign req_idx  = off[3 +: IdxW];

   assign ack_o = (state_q == IDLE) && req_i && !rst_i;

   assign nwords = nc_q ? CntW'(1) : CntW'(N);
   assign rd_en  = (state_q == READ) && (cnt_q < nwords);
   assign rd_idx = nc_q ? idx_q : ((idx_q & ~LineMask) + IdxW'(cnt_q));
   assign slot   = cnt_q - CntW'(1);

   // Word read in the previous cycle lands in slot cnt-1.
   always_comb begin
      line_next = line_q;
      if (cnt_q != '0) line_next[slot*64 +: 64] = rd_data;
   end

   always_ff @(posedge clk_i) begin
      if (rd_en) rd_data <= mem[rd_idx];
      if (state_q == WRITE && !rst_i) begin
         for (int b = 0; b < 8; b++) begin
            if (be_q[b]) mem[idx_q][8*b +: 8] <= data_q[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         nc_q         <= 1'b0;
         tid_q        <= '0;
         idx_q        <= '0;
         data_q       <= '0;
         be_q         <= '0;
         cnt_q        <= '0;
         line_q       <= '0;
         rtrn_vld_o   <= 1'b0;
         rtrn_rtype_o <= 2'b00;
         rtrn_tid_o   <= '0;
         rtrn_data_o  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  nc_q   <= req_nc_i;
                  tid_q  <= req_tid_i;
                  idx_q  <= req_idx;
                  data_q <= req_data_i;
                  be_q   <= req_be_i;
                  cnt_q  <= '0;
                  line_q <= '0;
                  if (req_err) begin
                     state_q      <= RESP;
                     rtrn_vld_o   <= 1'b1;
                     rtrn_rtype_o <= 2'b11;
                     rtrn_tid_o   <= req_tid_i;
                     rtrn_data_o  <= '0;
                  end else if (req_rtype_i[0]) begin
                     state_q <= WRITE;
                  end else begin
                     state_q <= READ;
                  end
               end
            end
            READ: begin
               line_q <= line_next;
               cnt_q  <= cnt_q + CntW'(1);
               if (cnt_q == nwords) begin
                  state_q      <= RESP;
                  rtrn_vld_o   <= 1'b1;
                  rtrn_rtype_o <= 2'b00;
                  rtrn_tid_o   <= tid_q;
                  rtrn_data_o  <= nc_q ? {N{rd_data}} : line_next;
               end
            end
            WRITE: begin
               state_q      <= RESP;
               rtrn_vld_o   <= 1'b1;
               rtrn_rtype_o <= 2'b01;
               rtrn_tid_o   <= tid_q;
               rtrn_data_o  <= '0;
            end
            RESP: begin
               state_q      <= IDLE;
               rtrn_vld_o   <= 1'b0;
               rtrn_rtype_o <= 2'b00;
               rtrn_tid_o   <= '0;
               rtrn_data_o  <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Directed bench for wt_dcache_mem_responder with default parameters (N = 2 words per line).
// Expected values are hand-computed constants.
module tb_wt_dcache_mem_responder;

   logic         clk_i;
   logic         rst_i;
   logic         req_i;
   logic         ack_o;
   logic [1:0]   req_rtype_i;
   logic         req_nc_i;
   logic [1:0]   req_tid_i;
   logic [63:0]  req_paddr_i;
   logic [63:0]  req_data_i;
   logic [7:0]   req_be_i;
   logic         rtrn_vld_o;
   logic [1:0]   rtrn_rtype_o;
   logic [1:0]   rtrn_tid_o;
   logic [127:0] rtrn_data_o;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   wt_dcache_mem_responder dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .ack_o       (ack_o),
      .req_rtype_i (req_rtype_i),
      .req_nc_i    (req_nc_i),
      .req_tid_i   (req_tid_i),
      .req_paddr_i (req_paddr_i),
      .req_data_i  (req_data_i),
      .req_be_i    (req_be_i),
      .rtrn_vld_o  (rtrn_vld_o),
      .rtrn_rtype_o(rtrn_rtype_o),
      .rtrn_tid_o  (rtrn_tid_o),
      .rtrn_data_o (rtrn_data_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns in cycle T0+1 (just after the accept edge) with req_i dropped.
   task automatic send(input logic [1:0] rt, input logic nc, input logic [1:0] tid,
                       input logic [63:0] pa, input logic [63:0] d, input logic [7:0] be);
      int w;
      req_rtype_i = rt;
      req_nc_i    = nc;
      req_tid_i   = tid;
      req_paddr_i = pa;
      req_data_i  = d;
      req_be_i    = be;
      req_i       = 1'b1;
      #1;
      w = 0;
      while (!ack_o && w < 10) begin
         @(posedge clk_i);
         #2;
         w++;
      end
      check("ack_wait", ack_o, 1);
      tick();
      req_i = 1'b0;
   endtask

   // Called in cycle T0+1; lat is the cycle offset from T0 where the pulse must appear.
   task automatic expect_rtrn(input string tag, input int lat, input logic [1:0] rt,
                              input logic [1:0] tid, input logic [127:0] d);
      int k;
      k = 1;
      while (!rtrn_vld_o && k < 12) begin
         tick();
         k++;
      end
      check({tag, "_lat"}, 128'(k), 128'(lat));
      check({tag, "_vld"}, rtrn_vld_o, 1);
      check({tag, "_rtype"}, rtrn_rtype_o, rt);
      check({tag, "_tid"}, rtrn_tid_o, tid);
      check({tag, "_data"}, rtrn_data_o, d);
      tick();
      check({tag, "_pulse"}, rtrn_vld_o, 0);
   endtask

   initial begin
      int w;
      rst_i       = 1'b1;
      req_i       = 1'b0;
      req_rtype_i = 2'b00;
      req_nc_i    = 1'b0;
      req_tid_i   = 2'd0;
      req_paddr_i = 64'h0;
      req_data_i  = 64'h0;
      req_be_i    = 8'h00;
      tick();
      tick();
      check("rst_ack", ack_o, 0);
      check("rst_vld", rtrn_vld_o, 0);
      check("rst_rtype", rtrn_rtype_o, 0);
      check("rst_tid", rtrn_tid_o, 0);
      check("rst_data", rtrn_data_o, 0);
      rst_i = 1'b0;
      tick();

      // Store then cacheable line load
      send(2'b01, 1'b0, 2'd1, 64'h8000_0010, 64'h1122334455667788, 8'hFF);
      expect_rtrn("st_full", 2, 2'b01, 2'd1, 128'h0);
      send(2'b01, 1'b0, 2'd0, 64'h8000_0018, 64'h0123456789ABCDEF, 8'hFF);
      expect_rtrn("st_w3", 2, 2'b01, 2'd0, 128'h0);
      send(2'b00, 1'b0, 2'd2, 64'h8000_0018, 64'h0, 8'h00);
      expect_rtrn("ld_line", 4, 2'b00, 2'd2,
                  {64'h0123456789ABCDEF, 64'h1122334455667788});

      // Partial store, NC load replicates
      send(2'b01, 1'b0, 2'd1, 64'h8000_0020, 64'h0, 8'hFF);
      expect_rtrn("st_zero", 2, 2'b01, 2'd1, 128'h0);
      send(2'b01, 1'b0, 2'd2, 64'h8000_0020, 64'hAABBCCDDEEFF0011, 8'h0F);
      expect_rtrn("st_part", 2, 2'b01, 2'd2, 128'h0);
      send(2'b00, 1'b1, 2'd3, 64'h8000_0020, 64'h0, 8'h00);
      expect_rtrn("nc_part", 3, 2'b00, 2'd3, {2{64'h00000000EEFF0011}});

      // Errors
      send(2'b00, 1'b0, 2'd0, 64'h7FFF_FFF8, 64'h0, 8'h00);
      expect_rtrn("err_low", 1, 2'b11, 2'd0, 128'h0);
      send(2'b00, 1'b0, 2'd1, 64'h8000_8000, 64'h0, 8'h00);
      expect_rtrn("err_high", 1, 2'b11, 2'd1, 128'h0);
      send(2'b10, 1'b0, 2'd3, 64'h8000_0000, 64'h0, 8'h00);
      expect_rtrn("err_amo", 1, 2'b11, 2'd3, 128'h0);
      send(2'b11, 1'b0, 2'd2, 64'h8000_0010, 64'h0, 8'hFF);
      expect_rtrn("err_rsvd", 1, 2'b11, 2'd2, 128'h0);

      // Last in-range word
      send(2'b01, 1'b0, 2'd0, 64'h8000_7FF8, 64'h0BADF00DDEADBEEF, 8'hFF);
      expect_rtrn("st_last", 2, 2'b01, 2'd0, 128'h0);
      send(2'b00, 1'b1, 2'd1, 64'h8000_7FF8, 64'h0, 8'h00);
      expect_rtrn("nc_last", 3, 2'b00, 2'd1, {2{64'h0BADF00DDEADBEEF}});

      // Back-to-back loads with req_i held
      req_rtype_i = 2'b00;
      req_nc_i    = 1'b0;
      req_tid_i   = 2'd1;
      req_paddr_i = 64'h8000_0010;
      req_i       = 1'b1;
      #1;
      w = 0;
      while (!ack_o && w < 10) begin
         @(posedge clk_i);
         #2;
         w++;
      end
      check("b2b_ack0", ack_o, 1);
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) req_tid_i = 2'd2;
         check("b2b_ack", ack_o, (c == 5));
         check("b2b_vld", rtrn_vld_o, (c == 4));
         if (c == 4) begin
            check("b2b_tid1", rtrn_tid_o, 2'd1);
            check("b2b_data1", rtrn_data_o, {64'h0123456789ABCDEF, 64'h1122334455667788});
         end
      end
      tick();
      req_i = 1'b0;
      check("b2b_noack", ack_o, 0);
      expect_rtrn("b2b_ld2", 4, 2'b00, 2'd2, {64'h0123456789ABCDEF, 64'h1122334455667788});

      // Reset in the WRITE cycle, request held across reset
      send(2'b01, 1'b0, 2'd0, 64'h8000_0030, 64'h5555666677778888, 8'hFF);
      expect_rtrn("st_old", 2, 2'b01, 2'd0, 128'h0);
      send(2'b01, 1'b0, 2'd1, 64'h8000_0030, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      rst_i = 1'b1;
      tick();
      check("mrst_ack", ack_o, 0);
      check("mrst_vld", rtrn_vld_o, 0);
      check("mrst_rtype", rtrn_rtype_o, 0);
      check("mrst_tid", rtrn_tid_o, 0);
      check("mrst_data", rtrn_data_o, 0);
      req_rtype_i = 2'b00;
      req_nc_i    = 1'b1;
      req_tid_i   = 2'd3;
      req_paddr_i = 64'h8000_0030;
      req_i       = 1'b1;
      #1;
      check("mrst_ack_held", ack_o, 0);
      tick();
      check("mrst_vld2", rtrn_vld_o, 0);
      rst_i = 1'b0;
      #1;
      check("mrst_ack_rel", ack_o, 1);
      tick();
      req_i = 1'b0;
      expect_rtrn("mrst_ld", 3, 2'b00, 2'd3, {2{64'h5555666677778888}});

      // be = 0 store
      send(2'b01, 1'b0, 2'd2, 64'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      expect_rtrn("st_be0", 2, 2'b01, 2'd2, 128'h0);
      send(2'b00, 1'b1, 2'd0, 64'h8000_0010, 64'h0, 8'h00);
      expect_rtrn("nc_be0", 3, 2'b00, 2'd0, {2{64'h1122334455667788}});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
